rom_burst_arbiter: RTL and testbench
====================================

ROM_BURST_ARBITER -- requirements
Module: rom_burst_arbiter

Interface
REQ-001 Parameter ROM_LAT, default 1, meaning: clock edges from a sampled rom_address to valid rom_rgb; legal range 1..4.
REQ-002 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 req_valid  input  2  per-requester burst request (bit i = requester i).
REQ-005 req_addr  input  2x12  per-requester burst start address, {y[5:0], x[5:0]}.
REQ-006 req_len  input  2x6  per-requester burst length minus one (beats = req_len+1, i.e. 1..64).
REQ-007 req_ready  output  2  one-hot acceptance strobe; a burst is accepted on an edge where req_valid[i] and req_ready[i] are both high.
REQ-008 rom_address  output  12  registered read address to the shared image ROM.
REQ-009 rom_rgb  input  12  ROM read data, valid ROM_LAT edges after rom_address is sampled.
REQ-010 rsp_valid  output  2  one-hot; returned pixel belongs to requester i.
REQ-011 rsp_rgb  output  12  returned pixel data, registered.
REQ-012 rsp_last  output  1  high with the final beat of a burst.
REQ-013 busy  output  1  high while the FSM is in BURST or any response is in flight.

Function
REQ-014 FSM states: IDLE and BURST, and no others.
REQ-015 In IDLE, req_ready is asserted combinationally for exactly one requester with req_valid high, and is all-zero when no request is pending.
REQ-016 On contention in IDLE, the requester not granted last wins (round-robin); a lone requester always wins.
REQ-017 In BURST, req_ready shall be 2'b00.
REQ-018 Acceptance edge E0 moves the FSM to BURST, loads rom_address <= req_addr[i], stores the owner id, and loads the beat counter with req_len[i].
REQ-019 Each subsequent edge in BURST increments rom_address by 1 (modulo 4096: 12'hFFF wraps to 12'h000) and decrements the counter.
REQ-020 The edge that ends the cycle with counter==0 returns the FSM to IDLE; rom_address then holds its last value.
REQ-021 Back-to-back bursts have exactly one IDLE (arbitration) cycle between the last beat address and the next first beat address.
REQ-022 Beat k (k=0..req_len) is presented on rom_address in the cycle after edge E_k.
REQ-023 The response for beat k appears in the cycle after edge E_(k+1+ROM_LAT) as: rsp_valid[owner]=1, rsp_rgb=rom_rgb, and rsp_last=(k==req_len).
REQ-024 Responses are in issue order with no backpressure; requesters shall accept every rsp_valid.
REQ-025 An in-flight pipeline (owner id, valid, last), ROM_LAT+1 stages deep, tracks responses independently of the FSM, so responses of burst N may overlap arbitration and issue of burst N+1.
REQ-026 rsp_valid is 2'b00 in every cycle with no response due.
REQ-027 req_addr and req_len are sampled only at the acceptance edge; changes afterwards do not affect the burst.
REQ-028 req_valid dropping during BURST has no effect on the burst in progress.

Reset
REQ-029 While rst is high, and immediately on its assertion: FSM=IDLE, rom_address=12'h000, rsp_valid=2'b00, rsp_rgb=12'h000, rsp_last=0, busy=0, pipeline cleared, counter=0, round-robin state set so requester 0 wins first contention.
REQ-030 Reset mid-burst aborts the burst; no response of the aborted burst is emitted after rst deasserts.
REQ-031 The first acceptance after reset release may occur in the first cycle rst is low.

Structure
REQ-032 Shared package rom_arb_pkg holds ADDR_W=12, RGB_W=12, LEN_W=6, N_REQ=2, and the FSM state enum (IDLE, BURST).
REQ-033 The response delay line is the sub-module rom_rsp_pipe (parameter DEPTH=ROM_LAT+1; carries valid, id, last).
REQ-034 The ROM itself stays outside this block; rom_address is driven from a flop, never combinationally.

Verification (bench ROM model rom[a]=a, ROM_LAT=1)
REQ-035 Single burst: req0 addr=12'h040, len=3 -> rom_address 040..043 on consecutive cycles; rsp_valid=01 with rsp_rgb 040..043 starting 2 cycles after first address; rsp_last only on 043.
REQ-036 Contention after reset: both valid, req0 len=0 addr=12'h010, req1 len=0 addr=12'h020 -> req0 granted first (rsp 010, rsp_valid=01), then one idle cycle, then req1 (rsp 020, rsp_valid=10).
REQ-037 Round-robin fairness: both requesters held valid continuously with len=1 -> grants alternate 0,1,0,1 over 8 bursts; no requester granted twice in a row.
REQ-038 Wrap: addr=12'hFFE, len=3 -> rom_address FFE, FFF, 000, 001; rsp_rgb same sequence.
REQ-039 Reset mid-burst: addr=12'h100, len=63; assert rst on beat 10 -> outputs at reset values immediately; no rsp_valid after release until a new burst.
REQ-040 Overlap: req0 len=0 followed at once by req1 len=0 -> req1 first address issued while req0's response is still in flight; both responses correct, with busy continuously high.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared widths, FSM state type and helpers for the two-requester ROM burst arbiter.
package rom_arb_pkg;
  localparam int ADDR_W = 12;
  localparam int RGB_W  = 12;
  localparam int LEN_W  = 6;
  localparam int N_REQ  = 2;
  localparam int ID_W   = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/rom_rsp_pipe.sv
// Response tag delay line (valid, owner id, last) matching the ROM read latency.
module rom_rsp_pipe
  import rom_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  input  logic            in_last,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output logic            out_last,
  output logic            any_valid
);

  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0]           last_q, last_d;
  logic [DEPTH-1:0][ID_W-1:0] id_q, id_d;

  // DEPTH is at least 2 because the ROM latency is at least 1.
  always_comb begin
    valid_d = {valid_q[DEPTH-2:0], in_valid};
    last_d  = {last_q[DEPTH-2:0], in_last};
    id_d    = {id_q[DEPTH-2:0], in_id};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      id_q    <= id_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_id    = id_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter issuing address bursts to a shared image ROM and routing pixels back.
module rom_burst_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [N_REQ-1:0][LEN_W-1:0]   req_len,
  output logic [N_REQ-1:0]              req_ready,
  output logic [ADDR_W-1:0]             rom_address,
  input  logic [RGB_W-1:0]              rom_rgb,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [RGB_W-1:0]              rsp_rgb,
  output logic                          rsp_last,
  output logic                          busy
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [RGB_W-1:0]   rsp_rgb_q, rsp_rgb_d;
  logic               rsp_last_q, rsp_last_d;

  logic [ID_W-1:0]    pick;
  logic               iss_valid;
  logic [ID_W-1:0]    iss_id;
  logic               iss_last;
  logic               pipe_valid;
  logic [ID_W-1:0]    pipe_id;
  logic               pipe_last;
  logic               pipe_any;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    iss_valid    = 1'b0;
    iss_id       = owner_q;
    iss_last     = 1'b0;
    // On contention the requester not served last wins.
    if (req_valid == '1) begin
      pick = ~last_grant_q;
    end else begin
      pick = req_valid[1] ? 1'b1 : 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid != '0) begin
          req_ready    = id_to_onehot(pick);
          state_d      = BURST;
          addr_d       = req_addr[pick];
          cnt_d        = req_len[pick];
          owner_d      = pick;
          last_grant_d = pick;
          iss_valid    = 1'b1;
          iss_id       = pick;
          iss_last     = (req_len[pick] == '0);
        end
      end
      BURST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          addr_d    = addr_q + ADDR_W'(1);
          cnt_d     = cnt_q - LEN_W'(1);
          iss_valid = 1'b1;
          iss_last  = (cnt_q == LEN_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  rom_rsp_pipe #(
    .DEPTH(ROM_LAT + 1)
  ) u_rsp_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (iss_valid),
    .in_id    (iss_id),
    .in_last  (iss_last),
    .out_valid(pipe_valid),
    .out_id   (pipe_id),
    .out_last (pipe_last),
    .any_valid(pipe_any)
  );

  always_comb begin
    rsp_valid_d = pipe_valid ? id_to_onehot(pipe_id) : '0;
    rsp_rgb_d   = pipe_valid ? rom_rgb : rsp_rgb_q;
    rsp_last_d  = pipe_valid & pipe_last;
  end

  // Requester 0 must win the first contention, so reset marks requester 1 as last served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      owner_q      <= '0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= '0;
      rsp_rgb_q    <= '0;
      rsp_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rgb_q    <= rsp_rgb_d;
      rsp_last_q   <= rsp_last_d;
    end
  end

  assign rom_address = addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rgb     = rsp_rgb_q;
  assign rsp_last    = rsp_last_q;
  assign busy        = (state_q == BURST) | pipe_any;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter with a one-cycle ROM returning rom[a] = a.
module tb_rom_burst_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0][11:0] req_addr;
  logic [1:0][5:0]  req_len;
  logic [1:0]       req_ready;
  logic [11:0]      rom_address;
  logic [11:0]      rom_rgb = 12'h000;
  logic [1:0]       rsp_valid;
  logic [11:0]      rsp_rgb;
  logic             rsp_last;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_rgb <= rom_address;

  rom_burst_arbiter #(.ROM_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .rom_address(rom_address),
    .rom_rgb    (rom_rgb),
    .rsp_valid  (rsp_valid),
    .rsp_rgb    (rsp_rgb),
    .rsp_last   (rsp_last),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_addr"}, rom_address, 12'h000);
    check_eq({tag, "_rsp_valid"}, 12'(rsp_valid), 12'h000);
    check_eq({tag, "_rsp_rgb"}, rsp_rgb, 12'h000);
    check_eq({tag, "_rsp_last"}, 12'(rsp_last), 12'h000);
    check_eq({tag, "_busy"}, 12'(busy), 12'h000);
  endtask

  // Called just after a rising edge with the arbiter idle; returns just after a rising edge.
  task automatic single_burst(input int id, input logic [11:0] a, input logic [5:0] len);
    logic [1:0]  oh;
    logic [11:0] ea;
    int          k;
    oh = 2'b01 << id;
    $display("[TB] burst req%0d addr=%h len=%0d", id, a, len);
    req_valid    = oh;
    req_addr[id] = a;
    req_len[id]  = len;
    @(negedge clk);
    check_eq("sb_ready", 12'(req_ready), 12'(oh));
    for (int c = 0; c <= int'(len) + 3; c++) begin
      @(posedge clk);
      #1;
      req_valid    = 2'b00;
      req_addr[id] = ~a;
      req_len[id]  = ~len;
      @(negedge clk);
      ea = a + 12'((c <= int'(len)) ? c : int'(len));
      check_eq("sb_addr", rom_address, ea);
      check_eq("sb_busy", 12'(busy), 12'(c <= int'(len) + 1));
      k = c - 2;
      if (k >= 0 && k <= int'(len)) begin
        check_eq("sb_rsp_valid", 12'(rsp_valid), 12'(oh));
        check_eq("sb_rsp_rgb", rsp_rgb, a + 12'(k));
        check_eq("sb_rsp_last", 12'(rsp_last), 12'(k == int'(len)));
      end else begin
        check_eq("sb_rsp_idle", 12'(rsp_valid), 12'h000);
        check_eq("sb_last_idle", 12'(rsp_last), 12'h000);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int cycles;

    rst       = 1'b1;
    req_valid = 2'b00;
    req_addr  = '0;
    req_len   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    check_eq("por_ready", 12'(req_ready), 12'h000);

    // Request presented in the very first cycle reset is low.
    @(posedge clk);
    #1;
    rst = 1'b0;
    single_burst(0, 12'h040, 6'd3);
    single_burst(1, 12'hFFE, 6'd3);

    // Asynchronous reset: visible before the next clock edge.
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] contention req0 addr=010 / req1 addr=020 len=0");
    req_valid   = 2'b11;
    req_addr[0] = 12'h010;
    req_addr[1] = 12'h020;
    req_len[0]  = 6'd0;
    req_len[1]  = 6'd0;
    @(negedge clk);
    check_eq("ct_ready0", 12'(req_ready), 12'h001);
    check_eq("ct_busy0", 12'(busy), 12'h000);
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    @(negedge clk);
    check_eq("ct_addr1", rom_address, 12'h010);
    check_eq("ct_ready1", 12'(req_ready), 12'h000);
    check_eq("ct_busy1", 12'(busy), 12'h001);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("ct_addr2", rom_address, 12'h010);
    check_eq("ct_ready2", 12'(req_ready), 12'h002);
    check_eq("ct_busy2", 12'(busy), 12'h001);
    check_eq("ct_rspv2", 12'(rsp_valid), 12'h000);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    check_eq("ct_addr3", rom_address, 12'h020);
    check_eq("ct_rspv3", 12'(rsp_valid), 12'h001);
    check_eq("ct_rgb3", rsp_rgb, 12'h010);
    check_eq("ct_last3", 12'(rsp_last), 12'h001);
    check_eq("ct_busy3", 12'(busy), 12'h001);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("ct_rspv4", 12'(rsp_valid), 12'h000);
    check_eq("ct_busy4", 12'(busy), 12'h001);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("ct_rspv5", 12'(rsp_valid), 12'h002);
    check_eq("ct_rgb5", rsp_rgb, 12'h020);
    check_eq("ct_last5", 12'(rsp_last), 12'h001);
    check_eq("ct_busy5", 12'(busy), 12'h000);

    // Both requesters held valid: grants must alternate starting from requester 0.
    @(posedge clk);
    #1;
    $display("[TB] fairness both valid len=1");
    req_valid   = 2'b11;
    req_addr[0] = 12'h200;
    req_addr[1] = 12'h300;
    req_len[0]  = 6'd1;
    req_len[1]  = 6'd1;
    grants = 0;
    cycles = 0;
    while (grants < 8 && cycles < 200) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        check_eq("rr_grant", 12'(req_ready), (grants % 2 == 0) ? 12'h001 : 12'h002);
        grants++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    check_eq("rr_count", 12'(grants), 12'd8);
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1;

    // Long burst aborted by reset on beat 10.
    $display("[TB] burst req0 addr=100 len=63 with reset on beat 10");
    req_valid   = 2'b01;
    req_addr[0] = 12'h100;
    req_len[0]  = 6'd63;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (10) @(posedge clk);
    #1;
    check_eq("mr_addr10", rom_address, 12'h10A);
    check_eq("mr_rspv10", 12'(rsp_valid), 12'h001);
    check_eq("mr_rgb10", rsp_rgb, 12'h108);
    rst = 1'b1;
    #1;
    check_reset_outputs("mr_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("mr_post_rspv", 12'(rsp_valid), 12'h000);
      check_eq("mr_post_busy", 12'(busy), 12'h000);
      @(posedge clk);
      #1;
    end
    single_burst(1, 12'h5A5, 6'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
